id_ex_sequencer: RTL

Pipeline controller sitting between instruction decode and the `decodeExecute` datapath. Holds one instruction (IR, busA, busB) in an output register and presents it to execute with a valid/ready handshake. Inserts a one-cycle bubble on load-use hazards and squashes the instruction after a `j`. Keeps issue, bubble and squash counters for lab performance reporting.

---
 rtl/rv_lab_pkg.sv | 28 ++
 rtl/id_ex_sequencer_if.sv | 33 +++
 rtl/reg_use_decode.sv | 39 +++
 rtl/id_ex_sequencer.sv | 105 ++++++++++
 4 files changed

// File: rtl/rv_lab_pkg.sv
// Shared RV lab constants: opcodes, load funct3, sequencer state encoding and
// the register-use record produced by the operand-read decoder.
package rv_lab_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] FUNCT3_LW = 3'b010;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef struct packed {
    logic       rs1_en;
    logic [4:0] rs1;
    logic       rs2_en;
    logic [4:0] rs2;
  } reg_use_t;

  function automatic logic is_lw(input logic [31:0] ir);
    return (ir[6:0] == OP_LOAD) && (ir[14:12] == FUNCT3_LW);
  endfunction

endpackage

// File: rtl/id_ex_sequencer_if.sv
// Decode-to-execute handshake bundle plus the sequencer's performance counters.
interface id_ex_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              inValid;
  logic              inReady;
  logic [DATA_W-1:0] inIR;
  logic [DATA_W-1:0] inBusA;
  logic [DATA_W-1:0] inBusB;
  logic              exValid;
  logic              exReady;
  logic [DATA_W-1:0] exIR;
  logic [DATA_W-1:0] exBusA;
  logic [DATA_W-1:0] exBusB;
  logic [CNT_W-1:0]  issueCount;
  logic [CNT_W-1:0]  bubbleCount;
  logic [CNT_W-1:0]  squashCount;

  // The sequencer side.
  modport slave (
    input  inValid, inIR, inBusA, inBusB, exReady,
    output inReady, exValid, exIR, exBusA, exBusB,
    output issueCount, bubbleCount, squashCount
  );

  // Decode/execute environment driving the sequencer.
  modport master (
    output inValid, inIR, inBusA, inBusB, exReady,
    input  inReady, exValid, exIR, exBusA, exBusB,
    input  issueCount, bubbleCount, squashCount
  );
endinterface

// File: rtl/reg_use_decode.sv
// Maps an instruction word to the source registers it reads; shared with the
// forwarding logic so both agree on which fields are real register reads.
module reg_use_decode
  import rv_lab_pkg::*;
(
  input  logic [31:0] ir,
  output reg_use_t    regs
);

  // Immediate and funct fields never name a source register.
  logic unused_fields;
  assign unused_fields = ^{ir[31:25], ir[14:12]};

  always_comb begin
    regs = '0;
    if (ir[1:0] == 2'b01) begin
      regs.rs1_en = 1'b1;
      regs.rs1    = ir[11:7];
    end else if (ir[1:0] == 2'b10) begin
      regs.rs1_en = 1'b1;
      regs.rs1    = ir[6:2];
    end else begin
      case (ir[6:0])
        OP_R, OP_STORE: begin
          regs.rs1_en = 1'b1;
          regs.rs1    = ir[19:15];
          regs.rs2_en = 1'b1;
          regs.rs2    = ir[24:20];
        end
        OP_IMM, OP_LOAD: begin
          regs.rs1_en = 1'b1;
          regs.rs1    = ir[19:15];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/id_ex_sequencer.sv
// One-entry ID/EX holding register with load-use bubble insertion, post-jump
// squash and saturating issue/bubble/squash counters.
module id_ex_sequencer
  import rv_lab_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  id_ex_sequencer_if.slave bus
);

  logic [0:0]        state_p1;
  logic [DATA_W-1:0] ir_p1;
  logic [DATA_W-1:0] bus_a_p1;
  logic [DATA_W-1:0] bus_b_p1;
  logic              squash_pending_p1;
  logic [CNT_W-1:0]  issue_cnt_p1;
  logic [CNT_W-1:0]  bubble_cnt_p1;
  logic [CNT_W-1:0]  squash_cnt_p1;

  reg_use_t   in_use;
  logic [4:0] ex_rd;
  logic       vld_p1;
  logic       hazard;
  logic       in_ready;
  logic       accept;
  logic       issue;
  logic       load;
  logic       squash;
  logic       jal_issue;
  logic       stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  reg_use_decode u_reg_use (
    .ir   (bus.inIR[31:0]),
    .regs (in_use)
  );

  assign vld_p1 = (state_p1 == ST_FULL);
  assign ex_rd  = ir_p1[11:7];

  // rd != 0 here makes any x0 source comparison impossible to match.
  assign hazard = vld_p1 && is_lw(ir_p1[31:0]) && (ex_rd != 5'd0) &&
                  ((in_use.rs1_en && (in_use.rs1 == ex_rd)) ||
                   (in_use.rs2_en && (in_use.rs2 == ex_rd)));

  // A pending squash swallows the input without touching the register, so the
  // hazard and downstream backpressure are irrelevant to it.
  assign in_ready  = squash_pending_p1 || ((!vld_p1 || bus.exReady) && !hazard);
  assign accept    = bus.inValid && in_ready;
  assign issue     = vld_p1 && bus.exReady;
  assign load      = accept && !squash_pending_p1;
  assign squash    = accept && squash_pending_p1;
  assign jal_issue = issue && (ir_p1[6:0] == OP_JAL);
  assign stall     = bus.inValid && hazard && !squash_pending_p1;

  // Stage p1: ID/EX holding register and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1          <= ST_EMPTY;
      ir_p1             <= '0;
      bus_a_p1          <= '0;
      bus_b_p1          <= '0;
      squash_pending_p1 <= 1'b0;
      issue_cnt_p1      <= '0;
      bubble_cnt_p1     <= '0;
      squash_cnt_p1     <= '0;
    end else begin
      if (load) begin
        state_p1 <= ST_FULL;
        ir_p1    <= bus.inIR;
        bus_a_p1 <= bus.inBusA;
        bus_b_p1 <= bus.inBusB;
      end else if (issue) begin
        state_p1 <= ST_EMPTY;
      end

      // A jump issuing re-arms the squash even if one is consumed this cycle.
      if (jal_issue) begin
        squash_pending_p1 <= 1'b1;
      end else if (squash) begin
        squash_pending_p1 <= 1'b0;
      end

      if (issue)  issue_cnt_p1  <= sat_inc(issue_cnt_p1);
      if (stall)  bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
      if (squash) squash_cnt_p1 <= sat_inc(squash_cnt_p1);
    end
  end

  assign bus.inReady     = in_ready;
  assign bus.exValid     = vld_p1;
  assign bus.exIR        = ir_p1;
  assign bus.exBusA      = bus_a_p1;
  assign bus.exBusB      = bus_b_p1;
  assign bus.issueCount  = issue_cnt_p1;
  assign bus.bubbleCount = bubble_cnt_p1;
  assign bus.squashCount = squash_cnt_p1;

endmodule
